// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default widths and the EX sequencer states.
// Imported by ex_stage, alu_core and the upstream ALU control unit.
package alu_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_REG_ADDR_W = 4;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MOVE = 3'b010;
    localparam logic [2:0] ALU_SWAP = 3'b011;

    typedef enum logic {
        IDLE,
        SWAP2
    } ex_state_e;

    // Codes with bit 2 set are no-ops that still occupy an output slot.
    function automatic logic is_alu_op(input logic [2:0] code);
        return !code[2];
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath of the execute stage: result and flags from control code and operands.
// No state; the caller registers everything.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [2:0]        i_alu_control,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_overflow
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, i_op_a} + {1'b0, i_op_b};
    // Top bit of the widened difference is the unsigned borrow.
    assign w_diff = {1'b0, i_op_a} - {1'b0, i_op_b};

    always_comb begin
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_alu_control)
            ALU_ADD: begin
                o_result   = w_sum[DATA_W-1:0];
                o_carry    = w_sum[DATA_W];
                o_overflow = (i_op_a[DATA_W-1] == i_op_b[DATA_W-1]) &&
                             (w_sum[DATA_W-1] != i_op_a[DATA_W-1]);
            end
            ALU_SUB: begin
                o_result   = w_diff[DATA_W-1:0];
                o_carry    = w_diff[DATA_W];
                o_overflow = (i_op_a[DATA_W-1] != i_op_b[DATA_W-1]) &&
                             (w_diff[DATA_W-1] != i_op_a[DATA_W-1]);
            end
            ALU_MOVE, ALU_SWAP: o_result = i_op_b;
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registered EX/MEM output slot with valid/ready handshake.
// SWAP is issued as two writeback beats, stalling upstream between them.
module ex_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [2:0]            i_alu_control,
    input  logic [DATA_W-1:0]     i_op_a,
    input  logic [DATA_W-1:0]     i_op_b,
    input  logic [REG_ADDR_W-1:0] i_op1_addr,
    input  logic [REG_ADDR_W-1:0] i_op2_addr,
    input  logic                  i_reg_write,
    input  logic                  i_flush,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_W-1:0]     o_result,
    output logic [REG_ADDR_W-1:0] o_wr_addr,
    output logic                  o_wr_en,
    output logic                  o_zero,
    output logic                  o_carry,
    output logic                  o_overflow
);

    ex_state_e             r_state;
    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_result;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic                  r_wr_en;
    logic                  r_zero;
    logic                  r_carry;
    logic                  r_overflow;
    logic [DATA_W-1:0]     r_swap_data;
    logic [REG_ADDR_W-1:0] r_swap_addr;
    logic                  r_swap_we;

    logic                  w_slot_free;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_alu_result;
    logic                  w_alu_carry;
    logic                  w_alu_overflow;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .i_alu_control (i_alu_control),
        .i_op_a        (i_op_a),
        .i_op_b        (i_op_b),
        .o_result      (w_alu_result),
        .o_carry       (w_alu_carry),
        .o_overflow    (w_alu_overflow)
    );

    assign w_slot_free = !r_out_valid || i_out_ready;
    assign o_in_ready  = i_rst_n && (r_state == IDLE) && w_slot_free && !i_flush;
    assign w_accept    = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_wr_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_swap_data <= '0;
            r_swap_addr <= '0;
            r_swap_we   <= 1'b0;
        end else if (i_flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_wr_en     <= 1'b0;
        end else if (r_state == SWAP2) begin
            if (w_slot_free) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b1;
                r_result    <= r_swap_data;
                r_wr_addr   <= r_swap_addr;
                r_wr_en     <= r_swap_we;
                r_zero      <= (r_swap_data == '0);
                r_carry     <= 1'b0;
                r_overflow  <= 1'b0;
            end
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_result;
            r_wr_addr   <= i_op1_addr;
            r_wr_en     <= i_reg_write && is_alu_op(i_alu_control);
            r_zero      <= (w_alu_result == '0);
            r_carry     <= w_alu_carry;
            r_overflow  <= w_alu_overflow;
            if (i_alu_control == ALU_SWAP) begin
                r_state     <= SWAP2;
                r_swap_data <= i_op_a;
                r_swap_addr <= i_op2_addr;
                r_swap_we   <= i_reg_write;
            end
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_en     = r_wr_en;
    assign o_zero      = r_zero;
    assign o_carry     = r_carry;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed scenarios then random traffic, checked against a
// queue-of-beats reference model (queue depth 2 means the second SWAP beat is pending).
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  op1_addr;
    logic [3:0]  op2_addr;
    logic        reg_write;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  wr_addr;
    logic        wr_en;
    logic        zero;
    logic        carry;
    logic        overflow;

    ex_stage dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_alu_control (alu_control),
        .i_op_a        (op_a),
        .i_op_b        (op_b),
        .i_op1_addr    (op1_addr),
        .i_op2_addr    (op2_addr),
        .i_reg_write   (reg_write),
        .i_flush       (flush),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_result      (result),
        .o_wr_addr     (wr_addr),
        .o_wr_en       (wr_en),
        .o_zero        (zero),
        .o_carry       (carry),
        .o_overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  addr;
        logic        we;
        logic        z;
        logic        c;
        logic        v;
        bit          chk_addr;
    } beat_t;

    beat_t mq[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    bit    reset_prev = 1'b1;
    bit    kill_prev  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int r, input logic [3:0] a, input logic we,
                                 input logic c, input logic v, input bit ca);
        beat_t b;
        b.res      = 16'(r);
        b.addr     = a;
        b.we       = we;
        b.z        = (16'(r) == 16'h0);
        b.c        = c;
        b.v        = v;
        b.chk_addr = ca;
        return b;
    endfunction

    // Reference: plain integer arithmetic on the presented instruction.
    task automatic push_instr();
        int ua = int'(op_a);
        int ub = int'(op_b);
        int sa = int'($signed(op_a));
        int sb = int'($signed(op_b));
        int s;
        case (alu_control)
            3'd0: begin
                s = sa + sb;
                mq.push_back(mk(ua + ub, op1_addr, reg_write, (ua + ub) > 65535,
                                (s > 32767) || (s < -32768), 1'b1));
            end
            3'd1: begin
                s = sa - sb;
                mq.push_back(mk(ua - ub, op1_addr, reg_write, ua < ub,
                                (s > 32767) || (s < -32768), 1'b1));
            end
            3'd2: mq.push_back(mk(ub, op1_addr, reg_write, 1'b0, 1'b0, 1'b1));
            3'd3: begin
                mq.push_back(mk(ub, op1_addr, reg_write, 1'b0, 1'b0, 1'b1));
                mq.push_back(mk(ua, op2_addr, reg_write, 1'b0, 1'b0, 1'b1));
            end
            default: mq.push_back(mk(0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        endcase
    endtask

    // Monitor / scoreboard: check outputs mid-cycle, then advance the model to the next edge.
    always @(negedge clk) begin
        bit exp_rdy;
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (out_valid && mq.size() > 0) begin
            chk("result", 32'(result), 32'(mq[0].res));
            chk("wr_en", 32'(wr_en), 32'(mq[0].we));
            chk("zero", 32'(zero), 32'(mq[0].z));
            chk("carry", 32'(carry), 32'(mq[0].c));
            chk("overflow", 32'(overflow), 32'(mq[0].v));
            if (mq[0].chk_addr) chk("wr_addr", 32'(wr_addr), 32'(mq[0].addr));
        end
        if (kill_prev) chk("killed_wr_en", 32'(wr_en), 32'd0);
        if (reset_prev) begin
            chk("reset_outputs", {8'h0, result, wr_addr, wr_en, zero, carry, overflow}, 32'd0);
        end
        exp_rdy = rst_n && (mq.size() < 2) && (mq.size() == 0 || out_ready) && !flush;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));

        reset_prev = !rst_n;
        kill_prev  = !rst_n || flush;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && exp_rdy) push_instr();
        end
    end

    task automatic drv(input logic rn, input logic v, input logic [2:0] c,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] a1, input logic [3:0] a2,
                       input logic rw, input logic fl, input logic rdy);
        rst_n       = rn;
        in_valid    = v;
        alu_control = c;
        op_a        = a;
        op_b        = b;
        op1_addr    = a1;
        op2_addr    = a2;
        reg_write   = rw;
        flush       = fl;
        out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drv(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, rdy);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [2:0] c;
        drv(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // ADD signed overflow
        drv(1'b1, 1'b1, 3'd0, 16'h7FFF, 16'h0001, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        // back-to-back SUBs at full throughput
        drv(1'b1, 1'b1, 3'd1, 16'h0005, 16'h0005, 4'd4, 4'd0, 1'b1, 1'b0, 1'b1);
        drv(1'b1, 1'b1, 3'd1, 16'h0001, 16'h0002, 4'd5, 4'd0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        // SWAP, free-flowing
        drv(1'b1, 1'b1, 3'd3, 16'hAAAA, 16'h5555, 4'd1, 4'd2, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        // SWAP under backpressure
        drv(1'b1, 1'b1, 3'd3, 16'h1111, 16'h2222, 4'd6, 4'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        // flush while in SWAP2
        drv(1'b1, 1'b1, 3'd3, 16'hAAAA, 16'h5555, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 16'h0001, 16'h0001, 4'd9, 4'd0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        // reset mid-SWAP, then MOVE
        drv(1'b1, 1'b1, 3'd3, 16'hAAAA, 16'h5555, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 3'd2, 16'hDEAD, 16'h1234, 4'd7, 4'd0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        // no-op code and SWAP onto the same register
        drv(1'b1, 1'b1, 3'd6, 16'h1234, 16'h5678, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1);
        drv(1'b1, 1'b1, 3'd3, 16'h0000, 16'h0042, 4'd5, 4'd5, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            drv(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), c, pick(), pick(),
                4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the ALU control unit.
- Consumes the 3-bit ALU control code plus the operands from ID/EX, computes the result, and holds it in a registered EX/MEM output slot with a valid/ready handshake.
- SWAP is a two-writeback operation. The block sequences it over two output beats and stalls upstream in between.

Parameters:
- DATA_W, 16, operand/result width.
- REG_ADDR_W, 4, register-file address width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  ID/EX holds a valid instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- alu_control  in  3  000 ADD, 001 SUB, 010 MOVE, 011 SWAP; other codes are no-ops.
- op_a  in  DATA_W  Op1 register value.
- op_b  in  DATA_W  Op2 register value.
- op1_addr  in  REG_ADDR_W  Op1 register number.
- op2_addr  in  REG_ADDR_W  Op2 register number.
- reg_write  in  1  instruction writes the register file.
- flush  in  1  kill in-flight work (branch/hazard).
- out_valid  out  1  EX/MEM slot holds a result.
- out_ready  in  1  MEM stage consumes the slot.
- result  out  DATA_W  write data.
- wr_addr  out  REG_ADDR_W  destination register.
- wr_en  out  1  register write enable.
- zero  out  1  result == 0.
- carry  out  1  ADD carry-out; SUB borrow (op_a < op_b, unsigned).
- overflow  out  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; out_valid, result, wr_addr, wr_en, zero, carry, overflow all 0. in_ready is 0 during the reset cycle. Reset mid-SWAP discards the second beat.
- Slot free = !out_valid || out_ready.
- in_ready = (state==IDLE) && slot_free && !flush. Accept = in_valid && in_ready.
- Latency: one cycle from accept to out_valid.
- ADD: result = op_a+op_b (mod 2^DATA_W). wr_addr=op1_addr. carry = bit DATA_W of the sum. overflow = operand signs equal and result sign differs.
- SUB: result = op_a-op_b. wr_addr=op1_addr. carry=borrow. overflow = operand signs differ and result sign differs from op_a.
- MOVE: result=op_b, wr_addr=op1_addr, carry=0, overflow=0.
- SWAP, beat 1 (on accept): result=op_b, wr_addr=op1_addr. Latch op_a and op2_addr; go to SWAP2.
- SWAP, beat 2 (in SWAP2, when slot_free): result=latched op_a, wr_addr=latched op2_addr; return to IDLE.
- SWAP flags: carry=0, overflow=0 on both beats.
- Codes 100-111: the slot is filled with result=0, wr_en=0, zero=1, carry=0, overflow=0. The bubble is preserved.
- wr_en = reg_write of the instruction on every beat, including both SWAP beats.
- zero is always derived from the registered result.
- States: IDLE and SWAP2.
  - IDLE -> SWAP2 on accepting SWAP.
  - SWAP2 -> IDLE when beat 2 loads, or on flush.
- Backpressure: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Simultaneous out_ready and accept in the same cycle: the old beat retires and the new beat loads (full throughput).
- Flush (priority over accept and over beat 2):
  - next cycle out_valid=0 and wr_en=0;
  - state=IDLE;
  - the instruction presented that cycle is not accepted.
- op1_addr==op2_addr on SWAP: both beats are issued unchanged. The last write (op_a) wins.

Decomposition:
- Shared package alu_pkg:
  - ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_MOVE=3'b010, ALU_SWAP=3'b011;
  - DATA_W / REG_ADDR_W defaults;
  - state enum {IDLE, SWAP2}.
  - The ALU control unit also imports this package.
- Sub-module alu_core: purely combinational. Maps (alu_control, op_a, op_b) to result/carry/overflow. ex_stage owns the handshake, the SWAP sequencer and the output registers.

Test Plan:
- ADD 16'h7FFF+16'h0001, reg_write=1, op1_addr=3 -> next cycle: out_valid=1, result=16'h8000, wr_addr=3, wr_en=1, overflow=1, carry=0, zero=0.
- SUB 16'h0005-16'h0005, then SUB 16'h0001-16'h0002 back-to-back with out_ready=1 -> beat 1: result=0, zero=1, carry=0. Beat 2: result=16'hFFFF, carry=1. in_ready stays 1 throughout.
- SWAP op_a=16'hAAAA, op_b=16'h5555, op1_addr=1, op2_addr=2 -> beat 1: result 16'h5555 to r1. Beat 2: 16'hAAAA to r2 on the next cycle. in_ready=0 during SWAP2.
- SWAP accepted with out_ready=0 held for 3 cycles -> beat 1 is held stable for 3 cycles; beat 2 appears only after the handshake; no beat is lost or duplicated.
- flush asserted in SWAP2 -> next cycle: out_valid=0, state IDLE, in_ready=1, no write to r2.
- rst_n=0 while out_valid=1 mid-SWAP -> next cycle all outputs are 0. After release, a MOVE op_b=16'h1234 to r7 produces result=16'h1234, wr_addr=7.
